// File: rtl/shape_pkg.sv
//==============================================================================
// Module   : shape_pkg
// Brief    : Field positions, keep codes, FSM states and read-back match rule.
// Revision : 1.0
//==============================================================================
`default_nettype none

package shape_pkg;

    localparam int SHAPE_MSB = 17;
    localparam int SHAPE_LSB = 16;
    localparam int OP_MSB    = 5;
    localparam int OP_LSB    = 0;

    localparam logic [1:0] KEEP_SHAPE = 2'b11;
    localparam logic [5:0] KEEP_OP    = 6'h3F;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        RESP  = 2'd3
    } issuer_state_e;

    // A field requested as all-ones means "keep current", so it is not compared.
    function automatic logic cmd_matches(input logic [31:0] req, input logic [31:0] rb);
        logic shape_ok;
        logic op_ok;
        shape_ok = (req[SHAPE_MSB:SHAPE_LSB] == KEEP_SHAPE) ||
                   (req[SHAPE_MSB:SHAPE_LSB] == rb[SHAPE_MSB:SHAPE_LSB]);
        op_ok    = (req[OP_MSB:OP_LSB] == KEEP_OP) ||
                   (req[OP_MSB:OP_LSB] == rb[OP_MSB:OP_LSB]);
        return shape_ok && op_ok;
    endfunction

endpackage

`default_nettype wire

// File: rtl/shape_cmd_fifo.sv
//==============================================================================
// Module   : shape_cmd_fifo
// Brief    : DEPTH x WIDTH command FIFO, wrap-bit pointers, async active-low reset.
// Revision : 1.0
//==============================================================================
`default_nettype none

module shape_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             w_push;
    logic             w_pop;

    assign empty_o    = (wr_ptr_q == rd_ptr_q);
    // Same slot index but different wrap bit: writer is a full lap ahead.
    assign full_o     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop_data_o = mem_q[rd_ptr_q[AW-1:0]];
    assign w_push     = push_i && !full_o;
    assign w_pop      = pop_i && !empty_o;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (w_push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            if (w_pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
    end

endmodule

`default_nettype wire

// File: rtl/shape_cmd_issuer.sv
//==============================================================================
// Module   : shape_cmd_issuer
// Brief    : Replays buffered commands to the SFR as write + read-back and reports match.
// Revision : 1.0
//==============================================================================
`default_nettype none

module shape_cmd_issuer
    import shape_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    input  logic [31:0]      cmd_data,
    output logic             cmd_ready,
    output logic             write,
    output logic [31:0]      write_data,
    output logic             read,
    input  logic [31:0]      read_data,
    output logic             resp_valid,
    output logic             resp_accepted,
    output logic [CNT_W-1:0] reject_count,
    output logic             busy
);

    localparam logic [CNT_W-1:0] REJ_MAX = {CNT_W{1'b1}};

    issuer_state_e    state_q, state_d;
    logic [31:0]      hold_q, hold_d;
    logic             acc_q, acc_d;
    logic [CNT_W-1:0] rej_q, rej_d;

    logic             w_push;
    logic             w_pop;
    logic             w_full;
    logic             w_empty;
    logic [31:0]      w_head;

    assign w_push       = cmd_valid && !w_full;
    assign cmd_ready    = !w_full;
    assign reject_count = rej_q;
    assign busy         = !w_empty || (state_q != IDLE);

    shape_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (w_push),
        .push_data_i (cmd_data),
        .pop_i       (w_pop),
        .pop_data_o  (w_head),
        .full_o      (w_full),
        .empty_o     (w_empty)
    );

    always_comb begin
        state_d       = state_q;
        hold_d        = hold_q;
        acc_d         = acc_q;
        rej_d         = rej_q;
        w_pop         = 1'b0;
        write         = 1'b0;
        read          = 1'b0;
        write_data    = '0;
        resp_valid    = 1'b0;
        resp_accepted = 1'b0;
        case (state_q)
            IDLE: begin
                if (!w_empty) begin
                    w_pop   = 1'b1;
                    hold_d  = w_head;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                write      = 1'b1;
                write_data = hold_q;
                state_d    = READ;
            end
            READ: begin
                read       = 1'b1;
                write_data = hold_q;
                acc_d      = cmd_matches(hold_q, read_data);
                state_d    = RESP;
            end
            RESP: begin
                resp_valid    = 1'b1;
                resp_accepted = acc_q;
                if (!acc_q && (rej_q != REJ_MAX)) rej_d = rej_q + CNT_W'(1);
                // Pop straight into the next write to sustain one command per three cycles.
                if (!w_empty) begin
                    w_pop   = 1'b1;
                    hold_d  = w_head;
                    state_d = WRITE;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            hold_q  <= '0;
            acc_q   <= 1'b0;
            rej_q   <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            acc_q   <= acc_d;
            rej_q   <= rej_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_shape_cmd_issuer.sv
//==============================================================================
// Module   : tb_shape_cmd_issuer
// Brief    : Directed and random stimulus against a queue-based model of the issuer.
// Revision : 1.0
//==============================================================================
`default_nettype none

module tb_shape_cmd_issuer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic [31:0] cmd_data = '0;
    logic [31:0] read_data = '0;

    logic        cmd_ready, write, read, resp_valid, resp_accepted, busy;
    logic [31:0] write_data;
    logic [7:0]  reject_count;

    logic        cmd_ready2, write2, read2, resp_valid2, resp_accepted2, busy2;
    logic [31:0] write_data2;
    logic [1:0]  reject_count2;

    always #5 clk = ~clk;

    shape_cmd_issuer #(.DEPTH(DEPTH), .CNT_W(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_data(cmd_data),
        .cmd_ready(cmd_ready), .write(write), .write_data(write_data), .read(read),
        .read_data(read_data), .resp_valid(resp_valid), .resp_accepted(resp_accepted),
        .reject_count(reject_count), .busy(busy)
    );

    shape_cmd_issuer #(.DEPTH(DEPTH), .CNT_W(2)) u_dut_sat (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_data(cmd_data),
        .cmd_ready(cmd_ready2), .write(write2), .write_data(write_data2), .read(read2),
        .read_data(read_data), .resp_valid(resp_valid2), .resp_accepted(resp_accepted2),
        .reject_count(reject_count2), .busy(busy2)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Model: pending queue plus one in-flight command and its cycles since pop
    // (1 = write cycle, 2 = read cycle, 3 = response cycle, 0 = none).
    logic [31:0] mq[$];
    logic [31:0] m_hold = '0;
    int          m_age = 0;
    logic        m_acc = 1'b0;
    int          m_rej = 0;
    int          m_rej2 = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: observed %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic model_match(input logic [31:0] req, input logic [31:0] rb);
        int rs, ro;
        rs = int'((req >> 16) & 32'd3);
        ro = int'(req & 32'd63);
        return (rs == 3 || rs == int'((rb >> 16) & 32'd3)) &&
               (ro == 63 || ro == int'(rb & 32'd63));
    endfunction

    function automatic logic [31:0] pick_rd(input logic [31:0] h);
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 3))
            0:       return h;
            1:       return r;
            2:       return {r[31:18], h[17:16], r[15:0]};
            default: return {r[31:6], h[5:0]};
        endcase
    endfunction

    function automatic logic [31:0] rand_cmd();
        logic [31:0] d;
        d = $urandom;
        if ($urandom_range(0, 3) == 0) d[17:16] = 2'b11;
        if ($urandom_range(0, 3) == 0) d[5:0]   = 6'h3F;
        return d;
    endfunction

    function automatic void model_reset();
        mq.delete();
        m_hold = '0;
        m_age  = 0;
        m_acc  = 1'b0;
        m_rej  = 0;
        m_rej2 = 0;
    endfunction

    task automatic check_outputs();
        chk("cmd_ready",     {31'd0, cmd_ready},     {31'd0, mq.size() < DEPTH});
        chk("write",         {31'd0, write},         {31'd0, m_age == 1});
        chk("read",          {31'd0, read},          {31'd0, m_age == 2});
        chk("write_data",    write_data,             (m_age == 1 || m_age == 2) ? m_hold : 32'd0);
        chk("resp_valid",    {31'd0, resp_valid},    {31'd0, m_age == 3});
        chk("resp_accepted", {31'd0, resp_accepted}, {31'd0, (m_age == 3) && m_acc});
        chk("reject_count",  {24'd0, reject_count},  32'(m_rej));
        chk("busy",          {31'd0, busy},          {31'd0, (mq.size() != 0) || (m_age != 0)});
        chk("sat_count",     {30'd0, reject_count2}, 32'(m_rej2));
        chk("sat_resp",      {31'd0, resp_valid2},   {31'd0, m_age == 3});
    endtask

    // One clock cycle, entered and left on the falling edge.
    task automatic cycle(input logic v, input logic [31:0] d,
                         input logic use_rdv, input logic [31:0] rdv);
        logic        push;
        logic [31:0] rv;
        rv = use_rdv ? rdv : ((m_age == 2) ? pick_rd(m_hold) : 32'($urandom));
        cmd_valid = v;
        cmd_data  = d;
        read_data = rv;
        #1;
        check_outputs();
        push = v && (mq.size() < DEPTH);
        if (m_age == 2) m_acc = model_match(m_hold, rv);
        if (m_age == 3 && !m_acc) begin
            if (m_rej < 255) m_rej++;
            if (m_rej2 < 3)  m_rej2++;
        end
        if (m_age == 1 || m_age == 2) begin
            m_age++;
        end else if (mq.size() > 0) begin
            m_hold = mq.pop_front();
            m_age  = 1;
        end else begin
            m_age = 0;
        end
        if (push) mq.push_back(d);
        @(negedge clk);
    endtask

    task automatic idle(input int n, input logic [31:0] rdv);
        for (int i = 0; i < n; i++) cycle(1'b0, 32'd0, 1'b1, rdv);
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [31:0] d;
        logic [1:0]  sat_exp [5];
        sat_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

        do_reset();

        // Basic accept, then a mismatched op/shape reject.
        cycle(1'b1, 32'h0001_0000, 1'b1, 32'h0001_0000);
        idle(4, 32'h0001_0000);
        chk("t1_rej", {24'd0, reject_count}, 32'd0);
        cycle(1'b1, 32'h0002_0011, 1'b1, 32'h0001_0000);
        idle(4, 32'h0001_0000);
        chk("t2_rej", {24'd0, reject_count}, 32'd1);

        // Keep-field commands.
        cycle(1'b1, 32'h0003_003F, 1'b1, 32'h1234_5678);
        idle(4, 32'h1234_5678);
        cycle(1'b1, 32'h0003_0010, 1'b1, 32'h0002_0010);
        idle(4, 32'h0002_0010);
        chk("t3_rej", {24'd0, reject_count}, 32'd1);

        // Host holds cmd_valid until the FIFO fills; data changes only after acceptance.
        d = 32'h0000_0100;
        for (int i = 0; i < 12; i++) begin
            logic acc;
            acc = (mq.size() < DEPTH);
            cycle(1'b1, d, 1'b0, 32'd0);
            if (acc) d = d + 32'd1;
        end
        idle(20, 32'd0);

        // Saturation of the narrow counter.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 32'h0000_0001, 1'b1, 32'h0000_0002);
            idle(4, 32'h0000_0002);
            chk("sat_seq", {30'd0, reject_count2}, {30'd0, sat_exp[i]});
        end
        chk("wide_after_sat", {24'd0, reject_count}, 32'd5);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 2) != 0, rand_cmd(), 1'b0, 32'd0);
        end
        idle(20, 32'd0);

        // Reset while reading with two commands still queued.
        cycle(1'b1, 32'h0001_0001, 1'b1, 32'd0);
        cycle(1'b1, 32'h0002_0002, 1'b1, 32'd0);
        cycle(1'b1, 32'h0000_0003, 1'b1, 32'd0);
        cmd_valid = 1'b0;
        #1;
        chk("pre_rst_read", {31'd0, read}, 32'd1);
        chk("pre_rst_busy", {31'd0, busy}, 32'd1);
        do_reset();
        chk("post_rst_ready", {31'd0, cmd_ready}, 32'd1);
        chk("post_rst_busy",  {31'd0, busy},      32'd0);
        idle(6, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
